// File: rtl/maze_cell_writer_pkg.sv
// Shared constants and types for the maze cell memory.
// The block drawer uses the same grid constants on the read side.
//   MAZE_W / MAZE_H : grid size in cells (29 x 13)
//   MAZE_CELLS      : total cells; address = y*MAZE_W + x, max MAZE_CELLS-1
//   ADDR_W          : memory address width
//   BLOCK_PX        : pixels per cell edge (drawer side)
//   FIFO_DEPTH      : request FIFO entries (power of 2)
package maze_cell_writer_pkg;

  localparam int MAZE_W     = 29;
  localparam int MAZE_H     = 13;
  localparam int MAZE_CELLS = MAZE_W * MAZE_H;
  localparam int ADDR_W     = 9;
  localparam int BLOCK_PX   = 8;
  localparam int FIFO_DEPTH = 4;

  localparam int X_W   = 5;
  localparam int Y_W   = 4;
  localparam int REQ_W = X_W + Y_W + 1;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } wr_state_t;

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic           data;
  } cell_req_t;

  // Linear cell address, widened to ADDR_W before the multiply so the
  // largest legal cell (28,12) -> 376 cannot be truncated.
  function automatic logic [ADDR_W-1:0] cell_addr(input logic [X_W-1:0] x,
                                                   input logic [Y_W-1:0] y);
    logic [ADDR_W-1:0] xa;
    logic [ADDR_W-1:0] ya;
    xa = ADDR_W'(x);
    ya = ADDR_W'(y);
    return ya * ADDR_W'(MAZE_W) + xa;
  endfunction

  function automatic logic cell_in_bounds(input logic [X_W-1:0] x,
                                          input logic [Y_W-1:0] y);
    return (32'(x) < 32'(MAZE_W)) && (32'(y) < 32'(MAZE_H));
  endfunction

endpackage

// File: rtl/maze_cell_writer_if.sv
// Cell update request channel (valid/ready).
//   req_valid : request present            (master -> slave)
//   req_ready : slave can accept           (slave -> master)
//   req_x     : cell column                (master -> slave)
//   req_y     : cell row                   (master -> slave)
//   req_data  : new cell value, 1 = wall   (master -> slave)
interface maze_cell_writer_if;
  import maze_cell_writer_pkg::*;

  logic           req_valid;
  logic           req_ready;
  logic [X_W-1:0] req_x;
  logic [Y_W-1:0] req_y;
  logic           req_data;

  modport master (output req_valid, output req_x, output req_y, output req_data,
                  input  req_ready);
  modport slave  (input  req_valid, input  req_x, input  req_y, input  req_data,
                  output req_ready);
endinterface

// File: rtl/maze_req_fifo.sv
// Small synchronous FIFO holding accepted cell update requests.
//   clock, resetn : clock, synchronous active-low reset (empties the FIFO)
//   push/push_data: write one entry (ignored when full)
//   pop/pop_data  : head entry is visible on pop_data; pop removes it
//   full/empty    : status flags
//   count         : number of stored entries
module maze_req_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_push;
  logic             do_pop;

  assign full     = (count_reg == CNT_W'(DEPTH));
  assign empty    = (count_reg == '0);
  assign count    = count_reg;
  assign pop_data = mem_reg[rd_ptr_reg];

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage carries no reset; only the pointers define validity.
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem_reg[wr_ptr_reg] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of 2.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      count_reg <= count_reg + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/maze_cell_writer.sv
// Write-side agent for the 29x13 maze cell memory (1 bit per cell).
// Cell updates arrive over a valid/ready channel, are bounds-checked and
// queued, then committed one per cycle to the memory write port. A
// clear_req pulse sweeps every cell with clear_data; clear takes priority
// over queued writes, so writes queued around a clear land after it.
//   clock, resetn : clock, synchronous active-low reset
//   req_if        : request channel (slave side)
//   clear_req     : one-cycle pulse, fill all cells with clear_data
//   clear_data    : fill value, sampled with clear_req
//   mem_address   : registered write address
//   mem_data      : registered write data
//   mem_wren      : registered write enable
//   busy          : FIFO non-empty, clear pending, or sweep running
//   clear_done    : one-cycle pulse the cycle after the last sweep write
//   err_oob       : one-cycle pulse after an out-of-range request is consumed
module maze_cell_writer
  import maze_cell_writer_pkg::*;
(
  input  logic              clock,
  input  logic              resetn,
  maze_cell_writer_if.slave req_if,
  input  logic              clear_req,
  input  logic              clear_data,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_data,
  output logic              mem_wren,
  output logic              busy,
  output logic              clear_done,
  output logic              err_oob
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MAZE_CELLS - 1);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  wr_state_t         state_reg, state_next;
  logic [ADDR_W-1:0] sweep_reg, sweep_next;
  logic              clear_pending_reg, clear_pending_next;
  logic              clear_fill_reg, clear_fill_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic              data_reg, data_next;
  logic              wren_reg, wren_next;
  logic              done_pipe_reg;
  logic              clear_done_reg;
  logic              err_oob_reg;
  logic              last_sweep;

  cell_req_t         in_req;
  cell_req_t         head_req;
  logic [REQ_W-1:0]  fifo_pop_data;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_pop;
  logic              accept;
  logic              req_in_bounds;
  logic              fifo_push;
  logic              clear_take;

  // Ready is held low during reset so nothing is accepted mid-reset.
  assign req_if.req_ready = resetn && !fifo_full;
  assign accept           = req_if.req_valid && req_if.req_ready;
  assign in_req           = cell_req_t'({req_if.req_x, req_if.req_y, req_if.req_data});
  assign req_in_bounds    = cell_in_bounds(req_if.req_x, req_if.req_y);
  // Out-of-range requests are consumed (handshake completes) but never stored.
  assign fifo_push        = accept && req_in_bounds;
  assign head_req         = cell_req_t'(fifo_pop_data);

  maze_req_fifo #(
    .WIDTH (REQ_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .resetn    (resetn),
    .push      (fifo_push),
    .push_data (in_req),
    .pop       (fifo_pop),
    .pop_data  (fifo_pop_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // A new clear is only taken when none is pending or running.
  assign clear_take = clear_req && !clear_pending_reg && (state_reg != ST_CLEAR);

  always_comb begin
    state_next         = state_reg;
    sweep_next         = sweep_reg;
    clear_pending_next = clear_pending_reg;
    clear_fill_next    = clear_fill_reg;
    addr_next          = addr_reg;
    data_next          = data_reg;
    wren_next          = 1'b0;
    fifo_pop           = 1'b0;
    last_sweep         = 1'b0;

    if (clear_take) begin
      clear_pending_next = 1'b1;
      clear_fill_next    = clear_data;
    end

    case (state_reg)
      ST_IDLE: begin
        if (clear_pending_reg) begin
          state_next         = ST_CLEAR;
          sweep_next         = '0;
          clear_pending_next = 1'b0;
        end else if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          wren_next = 1'b1;
          addr_next = cell_addr(head_req.x, head_req.y);
          data_next = head_req.data;
        end
      end
      ST_CLEAR: begin
        wren_next = 1'b1;
        addr_next = sweep_reg;
        data_next = clear_fill_reg;
        if (sweep_reg == LAST_ADDR) begin
          state_next = ST_IDLE;
          last_sweep = 1'b1;
        end else begin
          sweep_next = sweep_reg + ADDR_W'(1);
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_reg         <= ST_IDLE;
      sweep_reg         <= '0;
      clear_pending_reg <= 1'b0;
      clear_fill_reg    <= 1'b0;
      addr_reg          <= '0;
      data_reg          <= 1'b0;
      wren_reg          <= 1'b0;
      done_pipe_reg     <= 1'b0;
      clear_done_reg    <= 1'b0;
      err_oob_reg       <= 1'b0;
    end else begin
      state_reg         <= state_next;
      sweep_reg         <= sweep_next;
      clear_pending_reg <= clear_pending_next;
      clear_fill_reg    <= clear_fill_next;
      addr_reg          <= addr_next;
      data_reg          <= data_next;
      wren_reg          <= wren_next;
      // last_sweep marks the edge that registers address 376; clear_done
      // follows one cycle after that write is visible.
      done_pipe_reg     <= last_sweep;
      clear_done_reg    <= done_pipe_reg;
      err_oob_reg       <= accept && !req_in_bounds;
    end
  end

  assign mem_address = addr_reg;
  assign mem_data    = data_reg;
  assign mem_wren    = wren_reg;
  assign clear_done  = clear_done_reg;
  assign err_oob     = err_oob_reg;
  assign busy        = (fifo_count != '0) || clear_pending_reg || (state_reg == ST_CLEAR);

endmodule

// File: tb/tb_maze_cell_writer.sv
module tb_maze_cell_writer;

  localparam int W     = 29;
  localparam int H     = 13;
  localparam int CELLS = W * H;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       clear_req = 1'b0;
  logic       clear_data = 1'b0;
  logic [8:0] mem_address;
  logic       mem_data;
  logic       mem_wren;
  logic       busy;
  logic       clear_done;
  logic       err_oob;

  maze_cell_writer_if bus();

  maze_cell_writer dut (
    .clock       (clock),
    .resetn      (resetn),
    .req_if      (bus),
    .clear_req   (clear_req),
    .clear_data  (clear_data),
    .mem_address (mem_address),
    .mem_data    (mem_data),
    .mem_wren    (mem_wren),
    .busy        (busy),
    .clear_done  (clear_done),
    .err_oob     (err_oob)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  // Reference model: expected write stream and expected maze contents.
  logic [9:0] exp_q[$];
  logic [9:0] obs_q[$];
  bit         model_mem [CELLS];
  bit         shadow_mem [CELLS];
  int         exp_err = 0;
  int         err_pulses = 0;
  int         done_pulses = 0;
  int         bad_addr_writes = 0;

  // Monitor: records what the DUT actually writes.
  always @(negedge clock) begin
    if (mem_wren) begin
      obs_q.push_back({mem_address, mem_data});
      if (int'(mem_address) < CELLS) shadow_mem[mem_address] <= mem_data;
      else bad_addr_writes <= bad_addr_writes + 1;
    end
    if (err_oob) err_pulses <= err_pulses + 1;
    if (clear_done) done_pulses <= done_pulses + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $display("FAIL %s: observed %0d required %0d", tag, obs, expv);
      $error("check %s", tag);
    end
  endtask

  task automatic model_accept(input int x, input int y, input bit d);
    int a;
    if (x < W && y < H) begin
      a = y * W + x;
      exp_q.push_back({9'(a), d});
      model_mem[a] = d;
    end else begin
      exp_err++;
    end
  endtask

  task automatic model_clear(input bit d);
    for (int i = 0; i < CELLS; i++) begin
      exp_q.push_back({9'(i), d});
      model_mem[i] = d;
    end
  endtask

  task automatic send(input int x, input int y, input bit d);
    int  waited;
    bit  accepted;
    bus.req_x     = 5'(x);
    bus.req_y     = 4'(y);
    bus.req_data  = d;
    bus.req_valid = 1'b1;
    waited = 0;
    @(negedge clock);
    while (!bus.req_ready && waited < 1000) begin
      @(negedge clock);
      waited++;
    end
    accepted = bus.req_ready;
    @(posedge clock);
    #1;
    bus.req_valid = 1'b0;
    check("send_accept", 32'(accepted), 32'd1);
    if (accepted) model_accept(x, y, d);
    $display("[TB] req x=%0d y=%0d d=%0d accepted=%0d", x, y, d, accepted);
  endtask

  task automatic do_clear(input bit d);
    clear_req  = 1'b1;
    clear_data = d;
    @(posedge clock);
    #1;
    clear_req = 1'b0;
    model_clear(d);
    $display("[TB] clear data=%0d", d);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    @(negedge clock);
    while (busy && n < 2000) begin
      @(negedge clock);
      n++;
    end
    check({tag, "_idle"}, 32'(busy), 32'd0);
    repeat (3) @(negedge clock);
    @(posedge clock);
    #1;
  endtask

  task automatic check_writes(input string tag);
    int n;
    check({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check({tag, "_write"}, 32'(obs_q[i]), 32'(exp_q[i]));
      if (obs_q[i] !== exp_q[i]) break;
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic apply_reset();
    resetn = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    resetn = 1'b1;
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int mism;
    int base;
    bus.req_valid = 1'b0;
    bus.req_x     = '0;
    bus.req_y     = '0;
    bus.req_data  = 1'b0;

    // ---- Reset state ----
    apply_reset();
    @(negedge clock);
    check("rst_wren", 32'(mem_wren), 32'd0);
    check("rst_addr", 32'(mem_address), 32'd0);
    check("rst_data", 32'(mem_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(clear_done), 32'd0);
    check("rst_err", 32'(err_oob), 32'd0);
    check("rst_ready", 32'(bus.req_ready), 32'd1);
    @(posedge clock);
    #1;

    // ---- Test 1: single request, one-cycle latency ----
    send(3, 2, 1'b1);
    @(negedge clock);
    check("t1_wren_early", 32'(mem_wren), 32'd0);
    check("t1_busy", 32'(busy), 32'd1);
    @(negedge clock);
    check("t1_wren", 32'(mem_wren), 32'd1);
    check("t1_addr", 32'(mem_address), 32'd61);
    check("t1_data", 32'(mem_data), 32'd1);
    check("t1_busy_fall", 32'(busy), 32'd0);
    wait_idle("t1");
    check_writes("t1");

    // ---- Test 2: FIFO fills while a clear stalls the pop path ----
    do_clear(1'b0);
    send(1, 1, 1'b1);
    send(2, 1, 1'b1);
    send(3, 1, 1'b0);
    send(4, 1, 1'b1);
    @(negedge clock);
    check("t2_ready_full", 32'(bus.req_ready), 32'd0);
    @(posedge clock);
    #1;
    send(5, 1, 1'b1);
    wait_idle("t2");
    check_writes("t2");

    // ---- Test 3: out-of-range requests ----
    base = err_pulses;
    send(29, 0, 1'b1);
    @(negedge clock);
    check("t3_err_a", 32'(err_oob), 32'd1);
    @(posedge clock);
    #1;
    send(0, 13, 1'b0);
    @(negedge clock);
    check("t3_err_b", 32'(err_oob), 32'd1);
    check("t3_wren", 32'(mem_wren), 32'd0);
    wait_idle("t3");
    check("t3_err_count", 32'(err_pulses - base), 32'd2);
    check_writes("t3");

    // ---- Test 4: clear sweep, consecutive writes, clear_done timing ----
    base = done_pulses;
    do_clear(1'b1);
    n = 0;
    @(negedge clock);
    while (!mem_wren && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("t4_sweep_start", 32'(mem_wren), 32'd1);
    mism = 0;
    for (int i = 0; i < CELLS; i++) begin
      if (!(mem_wren === 1'b1 && int'(mem_address) == i && mem_data === 1'b1)) mism++;
      @(negedge clock);
    end
    check("t4_sweep_mismatches", 32'(mism), 32'd0);
    check("t4_done_pulse", 32'(clear_done), 32'd1);
    check("t4_wren_after", 32'(mem_wren), 32'd0);
    @(negedge clock);
    check("t4_done_low", 32'(clear_done), 32'd0);
    wait_idle("t4");
    check("t4_done_count", 32'(done_pulses - base), 32'd1);
    check_writes("t4");

    // ---- Test 5: clear and enqueue in the same cycle ----
    clear_req     = 1'b1;
    clear_data    = 1'b1;
    bus.req_x     = 5'd28;
    bus.req_y     = 4'd12;
    bus.req_data  = 1'b0;
    bus.req_valid = 1'b1;
    @(negedge clock);
    check("t5_ready", 32'(bus.req_ready), 32'd1);
    @(posedge clock);
    #1;
    clear_req     = 1'b0;
    bus.req_valid = 1'b0;
    model_clear(1'b1);
    model_accept(28, 12, 1'b0);
    $display("[TB] clear data=1 with req x=28 y=12 d=0");
    wait_idle("t5");
    check("t5_cell376", 32'(shadow_mem[376]), 32'd0);
    check("t5_cell375", 32'(shadow_mem[375]), 32'd1);
    check_writes("t5");

    // ---- Test 6: reset in the middle of a sweep ----
    base = done_pulses;
    do_clear(1'b1);
    n = 0;
    @(negedge clock);
    while (!(mem_wren && mem_address == 9'd100) && n < 500) begin
      @(negedge clock);
      n++;
    end
    check("t6_reach_100", 32'(mem_address), 32'd100);
    resetn = 1'b0;
    @(negedge clock);
    check("t6_wren", 32'(mem_wren), 32'd0);
    check("t6_addr", 32'(mem_address), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_ready", 32'(bus.req_ready), 32'd0);
    @(posedge clock);
    #1;
    resetn = 1'b1;
    obs_q.delete();
    exp_q.delete();
    repeat (400) @(negedge clock);
    @(posedge clock);
    #1;
    check("t6_no_done", 32'(done_pulses - base), 32'd0);
    check("t6_no_writes", 32'(obs_q.size()), 32'd0);
    obs_q.delete();
    send(3, 2, 1'b1);
    @(negedge clock);
    check("t6_wren_early", 32'(mem_wren), 32'd0);
    @(negedge clock);
    check("t6_wren", 32'(mem_wren), 32'd1);
    check("t6_addr61", 32'(mem_address), 32'd61);
    check("t6_data", 32'(mem_data), 32'd1);
    wait_idle("t6");
    check_writes("t6");

    // ---- Randomized traffic against the maze model ----
    do_clear(1'($urandom_range(0, 1)));
    for (int k = 0; k < 80; k++) begin
      if ($urandom_range(0, 11) == 0) begin
        wait_idle("rnd_pre_clear");
        do_clear(1'($urandom_range(0, 1)));
      end else begin
        send(int'($urandom_range(0, 31)), int'($urandom_range(0, 15)),
             1'($urandom_range(0, 1)));
        if ($urandom_range(0, 3) == 0) begin
          repeat ($urandom_range(1, 4)) @(posedge clock);
          #1;
        end
      end
    end
    wait_idle("rnd");
    check_writes("rnd");
    mism = 0;
    for (int i = 0; i < CELLS; i++) begin
      if (shadow_mem[i] !== model_mem[i]) mism++;
    end
    check("rnd_maze_contents", 32'(mism), 32'd0);
    check("err_total", 32'(err_pulses), 32'(exp_err));
    check("no_oob_writes", 32'(bad_addr_writes), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
